// File: rtl/interrupt_sequencer.sv
// Interrupt entry sequencer: waits for a safe pipeline point, pushes PC-high, PC-low and
// flags through the stack path, loads the vector PC, then stalls while the pipeline drains.
module interrupt_sequencer #(
    parameter int unsigned PC_W         = 32,
    parameter int unsigned DATA_W       = 16,
    parameter int unsigned FLAG_W       = 3,
    parameter int unsigned DRAIN_CYCLES = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              int_req,
    input  logic              busy_seq,
    input  logic              branch_pending,
    input  logic              reti_done,
    input  logic [PC_W-1:0]   pc_cur,
    input  logic [FLAG_W-1:0] flags_in,
    input  logic [PC_W-1:0]   vec_pc,
    output logic              stall,
    output logic              inject_push,
    output logic [DATA_W-1:0] push_data,
    output logic              pc_load,
    output logic [PC_W-1:0]   pc_load_val,
    output logic              int_ack,
    output logic              int_active,
    output logic [2:0]        seq_state
);

    typedef enum logic [2:0] {
        StIdle     = 3'd0,
        StWaitSafe = 3'd1,
        StPushH    = 3'd2,
        StPushL    = 3'd3,
        StPushF    = 3'd4,
        StLoad     = 3'd5,
        StDrain    = 3'd6
    } state_e;

    localparam int unsigned DrainM1   = (DRAIN_CYCLES == 0) ? 0 : DRAIN_CYCLES - 1;
    localparam logic [3:0]  DrainInit = DrainM1[3:0];

    state_e              state_q, state_d;
    logic                int_req_q;
    logic                pending_q, pending_d;
    logic                int_active_q, int_active_d;
    logic [PC_W-1:0]     pc_q, pc_d;
    logic [FLAG_W-1:0]   flags_q, flags_d;
    logic [3:0]          cnt_q, cnt_d;

    always_comb begin
        state_d      = state_q;
        pc_d         = pc_q;
        flags_d      = flags_q;
        cnt_d        = cnt_q;
        pending_d    = pending_q | (int_req & ~int_req_q);
        int_active_d = int_active_q & ~reti_done;
        unique case (state_q)
            StIdle: begin
                if (pending_q && !int_active_q) begin
                    state_d = StWaitSafe;
                end
            end
            StWaitSafe: begin
                if (!busy_seq && !branch_pending) begin
                    state_d = StPushH;
                    pc_d    = pc_cur;
                    flags_d = flags_in;
                end
            end
            StPushH: state_d = StPushL;
            StPushL: state_d = StPushF;
            StPushF: state_d = StLoad;
            StLoad: begin
                // A fresh edge in this very cycle still survives the clear.
                pending_d    = int_req & ~int_req_q;
                int_active_d = 1'b1;
                cnt_d        = DrainInit;
                state_d      = (DRAIN_CYCLES == 0) ? StIdle : StDrain;
            end
            StDrain: begin
                if (cnt_q == 4'd0) begin
                    state_d = StIdle;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= StIdle;
            int_req_q    <= 1'b0;
            pending_q    <= 1'b0;
            int_active_q <= 1'b0;
            pc_q         <= '0;
            flags_q      <= '0;
            cnt_q        <= 4'd0;
        end else begin
            state_q      <= state_d;
            int_req_q    <= int_req;
            pending_q    <= pending_d;
            int_active_q <= int_active_d;
            pc_q         <= pc_d;
            flags_q      <= flags_d;
            cnt_q        <= cnt_d;
        end
    end

    always_comb begin
        stall       = 1'b0;
        inject_push = 1'b0;
        push_data   = '0;
        pc_load     = 1'b0;
        pc_load_val = '0;
        int_ack     = 1'b0;
        unique case (state_q)
            StPushH: begin
                stall       = 1'b1;
                inject_push = 1'b1;
                push_data   = pc_q[PC_W-1:DATA_W];
            end
            StPushL: begin
                stall       = 1'b1;
                inject_push = 1'b1;
                push_data   = pc_q[DATA_W-1:0];
            end
            StPushF: begin
                stall                  = 1'b1;
                inject_push            = 1'b1;
                push_data[FLAG_W-1:0]  = flags_q;
            end
            StLoad: begin
                stall       = 1'b1;
                pc_load     = 1'b1;
                pc_load_val = vec_pc;
                int_ack     = 1'b1;
            end
            StDrain: stall = 1'b1;
            default: ;
        endcase
    end

    assign int_active = int_active_q;
    assign seq_state  = state_q;

endmodule

// File: tb/tb_interrupt_sequencer.sv
// Scoreboard bench for interrupt_sequencer: expected output events are queued with their
// cycle stamps and a negedge monitor pops one for every cycle the DUT shows activity.
module tb_interrupt_sequencer;

    typedef struct packed {
        int unsigned cyc;
        logic        stall;
        logic        inject;
        logic [15:0] data;
        logic        load;
        logic [31:0] load_val;
        logic        ack;
    } ev_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        int_req = 1'b0;
    logic        int_req0 = 1'b0;
    logic        busy_seq = 1'b0;
    logic        branch_pending = 1'b0;
    logic        reti_done = 1'b0;
    logic [31:0] pc_cur = '0;
    logic [2:0]  flags_in = '0;
    logic [31:0] vec_pc = '0;

    logic        stall, inject_push, pc_load, int_ack, int_active;
    logic [15:0] push_data;
    logic [31:0] pc_load_val;
    logic [2:0]  seq_state;

    logic        stall0, inject_push0, pc_load0, int_ack0, int_active0;
    logic [15:0] push_data0;
    logic [31:0] pc_load_val0;
    logic [2:0]  seq_state0;

    int unsigned cyc = 0;
    int          n_cmp = 0;
    int          n_err = 0;
    ev_t         q[$];
    ev_t         q0[$];

    interrupt_sequencer dut (
        .clk            (clk),
        .rst            (rst),
        .int_req        (int_req),
        .busy_seq       (busy_seq),
        .branch_pending (branch_pending),
        .reti_done      (reti_done),
        .pc_cur         (pc_cur),
        .flags_in       (flags_in),
        .vec_pc         (vec_pc),
        .stall          (stall),
        .inject_push    (inject_push),
        .push_data      (push_data),
        .pc_load        (pc_load),
        .pc_load_val    (pc_load_val),
        .int_ack        (int_ack),
        .int_active     (int_active),
        .seq_state      (seq_state)
    );

    interrupt_sequencer #(.DRAIN_CYCLES(0)) dut0 (
        .clk            (clk),
        .rst            (rst),
        .int_req        (int_req0),
        .busy_seq       (busy_seq),
        .branch_pending (branch_pending),
        .reti_done      (reti_done),
        .pc_cur         (pc_cur),
        .flags_in       (flags_in),
        .vec_pc         (vec_pc),
        .stall          (stall0),
        .inject_push    (inject_push0),
        .push_data      (push_data0),
        .pc_load        (pc_load0),
        .pc_load_val    (pc_load_val0),
        .int_ack        (int_ack0),
        .int_active     (int_active0),
        .seq_state      (seq_state0)
    );

    initial forever #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        n_cmp++;
        if (act !== req) begin
            n_err++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    // Queue the full entry trace: three pushes, the vector load, then the drain stalls.
    task automatic exp_seq(input int unsigned base, input logic [31:0] pc, input logic [2:0] fl,
                           input logic [31:0] vec, input int drain, input bit to_zero);
        ev_t e;
        logic [15:0] words [3];
        words[0] = pc[31:16];
        words[1] = pc[15:0];
        words[2] = {13'd0, fl};
        for (int i = 0; i < 3; i++) begin
            e = '{cyc: base + i, stall: 1'b1, inject: 1'b1, data: words[i],
                  load: 1'b0, load_val: 32'd0, ack: 1'b0};
            if (to_zero) q0.push_back(e); else q.push_back(e);
        end
        e = '{cyc: base + 3, stall: 1'b1, inject: 1'b0, data: 16'd0,
              load: 1'b1, load_val: vec, ack: 1'b1};
        if (to_zero) q0.push_back(e); else q.push_back(e);
        for (int d = 0; d < drain; d++) begin
            e = '{cyc: base + 4 + d, stall: 1'b1, inject: 1'b0, data: 16'd0,
                  load: 1'b0, load_val: 32'd0, ack: 1'b0};
            if (to_zero) q0.push_back(e); else q.push_back(e);
        end
    endtask

    always @(negedge clk) begin
        ev_t act;
        ev_t req;
        if (stall || inject_push || pc_load || int_ack) begin
            act = '{cyc: cyc, stall: stall, inject: inject_push, data: push_data,
                    load: pc_load, load_val: pc_load_val, ack: int_ack};
            n_cmp++;
            if (q.size() == 0) begin
                n_err++;
                $display("FAIL unexpected_event actual=%h required=none", act);
            end else begin
                req = q.pop_front();
                if (act !== req) begin
                    n_err++;
                    $display("FAIL event actual=%h required=%h", act, req);
                end
            end
        end
    end

    always @(negedge clk) begin
        ev_t act;
        ev_t req;
        if (stall0 || inject_push0 || pc_load0 || int_ack0) begin
            act = '{cyc: cyc, stall: stall0, inject: inject_push0, data: push_data0,
                    load: pc_load0, load_val: pc_load_val0, ack: int_ack0};
            n_cmp++;
            if (q0.size() == 0) begin
                n_err++;
                $display("FAIL unexpected_event0 actual=%h required=none", act);
            end else begin
                req = q0.pop_front();
                if (act !== req) begin
                    n_err++;
                    $display("FAIL event0 actual=%h required=%h", act, req);
                end
            end
        end
    end

    initial begin
        int unsigned base;

        repeat (3) tick();
        check("rst_outputs", {stall, inject_push, pc_load, int_ack, int_active}, 64'd0);
        check("rst_data", {push_data, pc_load_val}, 64'd0);
        check("rst_state", seq_state, 64'd0);
        rst = 1'b0;
        tick();

        // Reset in PUSH_L: only PUSH_H and PUSH_L may appear.
        base = cyc;
        pc_cur = 32'hDEAD_BEEF; flags_in = 3'b011; vec_pc = 32'h200;
        int_req = 1'b1;
        exp_seq(base + 3, 32'hDEAD_BEEF, 3'b011, 32'h200, 0, 1'b0);
        void'(q.pop_back());
        void'(q.pop_back());
        repeat (4) tick();
        check("t1_in_push_l", seq_state, 64'd3);
        rst = 1'b1;
        int_req = 1'b0;
        tick();
        check("t1_state", seq_state, 64'd0);
        check("t1_outputs", {stall, inject_push, pc_load, int_ack, int_active}, 64'd0);
        check("t1_data", {push_data, pc_load_val}, 64'd0);
        rst = 1'b0;
        repeat (6) tick();
        check("t1_queue_drained", q.size(), 64'd0);

        // Basic entry with an idle pipeline.
        base = cyc;
        pc_cur = 32'h0001_2345; flags_in = 3'b101; vec_pc = 32'h100;
        int_req = 1'b1;
        exp_seq(base + 3, 32'h0001_2345, 3'b101, 32'h100, 2, 1'b0);
        repeat (10) tick();
        check("t2_active", int_active, 64'd1);
        int_req = 1'b0;
        reti_done = 1'b1;
        tick();
        reti_done = 1'b0;
        tick();
        check("t2_unmasked", int_active, 64'd0);

        // busy_seq holds WAIT_SAFE four extra cycles; PC captured at the exit edge.
        base = cyc;
        pc_cur = 32'h1111_2222; flags_in = 3'b001;
        busy_seq = 1'b1;
        int_req = 1'b1;
        exp_seq(base + 7, 32'hCAFE_0042, 3'b110, 32'h100, 2, 1'b0);
        repeat (4) tick();
        check("t3_wait_state", seq_state, 64'd1);
        check("t3_wait_stall", stall, 64'd0);
        repeat (2) tick();
        busy_seq = 1'b0;
        pc_cur = 32'hCAFE_0042; flags_in = 3'b110;
        tick();
        pc_cur = 32'h5555_6666; flags_in = 3'b010;
        repeat (8) tick();
        int_req = 1'b0;
        tick();

        // Masked edge waits for reti_done, then is serviced exactly once.
        int_req = 1'b1;
        repeat (5) tick();
        check("t4_masked_state", seq_state, 64'd0);
        check("t4_masked_active", int_active, 64'd1);
        pc_cur = 32'h0A0B_0C0D; flags_in = 3'b100; vec_pc = 32'h0000_4000;
        base = cyc;
        reti_done = 1'b1;
        exp_seq(base + 3, 32'h0A0B_0C0D, 3'b100, 32'h0000_4000, 2, 1'b0);
        tick();
        reti_done = 1'b0;
        int_req = 1'b0;
        repeat (12) tick();
        check("t4_active_again", int_active, 64'd1);
        check("t4_queue_drained", q.size(), 64'd0);

        // reti_done in the LOAD cycle loses to the set.
        reti_done = 1'b1;
        tick();
        reti_done = 1'b0;
        tick();
        check("t5_cleared", int_active, 64'd0);
        base = cyc;
        pc_cur = 32'h7777_8888; flags_in = 3'b111; vec_pc = 32'hFFFF_0000;
        int_req = 1'b1;
        exp_seq(base + 3, 32'h7777_8888, 3'b111, 32'hFFFF_0000, 2, 1'b0);
        repeat (6) tick();
        check("t5_in_load", seq_state, 64'd5);
        reti_done = 1'b1;
        tick();
        reti_done = 1'b0;
        check("t5_set_wins", int_active, 64'd1);
        repeat (4) tick();
        int_req = 1'b0;
        check("t5_still_active", int_active, 64'd1);
        reti_done = 1'b1;
        tick();
        reti_done = 1'b0;
        check("t5_reti_clears", int_active, 64'd0);
        tick();

        // Zero-drain build returns from LOAD straight to IDLE.
        base = cyc;
        pc_cur = 32'h1234_5678; flags_in = 3'b010; vec_pc = 32'h0000_0800;
        int_req0 = 1'b1;
        exp_seq(base + 3, 32'h1234_5678, 3'b010, 32'h0000_0800, 0, 1'b1);
        repeat (7) tick();
        check("t6_idle_after_load", seq_state0, 64'd0);
        check("t6_active", int_active0, 64'd1);
        int_req0 = 1'b0;
        repeat (4) tick();

        check("final_queue", q.size(), 64'd0);
        check("final_queue0", q0.size(), 64'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
